// File: rtl/switch_box_pkg.sv
// Shared routing-fabric definitions for the switch box.
// Contents:
//   sel_e              - 2-bit output select encoding (OFF plus three source sides)
//   CFG_BITS_PER_TRACK - configuration bits owned by one track (4 outputs x 2 bits)
//   sel3               - 4:1 select helper; SEL_OFF forces the output low
package switch_box_pkg;

  typedef enum logic [1:0] {
    SEL_OFF = 2'd0,
    SEL_A   = 2'd1,
    SEL_B   = 2'd2,
    SEL_C   = 2'd3
  } sel_e;

  localparam int CFG_BITS_PER_TRACK = 8;

  // Picks one of three source sides; the output's own side is never a candidate.
  function automatic logic sel3(input sel_e sel, input logic a, input logic b, input logic c);
    logic y;
    case (sel)
      SEL_OFF: y = 1'b0;
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/switch_box_track_mux.sv
// sb_track_mux: routing for one track index across the four sides.
// Ports:
//   field  [7:0] - track configuration: [1:0] l_out, [3:2] r_out, [5:4] t_out, [7:6] b_out
//   l_in/r_in/t_in/b_in   - this track's input on each side
//   l_out/r_out/t_out/b_out - this track's output on each side (combinational)
module sb_track_mux
  import switch_box_pkg::*;
(
  input  logic [CFG_BITS_PER_TRACK-1:0] field,
  input  logic                          l_in,
  input  logic                          r_in,
  input  logic                          t_in,
  input  logic                          b_in,
  output logic                          l_out,
  output logic                          r_out,
  output logic                          t_out,
  output logic                          b_out
);

  // Each output chooses among the other three sides in left, right, top, bottom order.
  always_comb begin
    l_out = sel3(sel_e'(field[1:0]), r_in, t_in, b_in);
    r_out = sel3(sel_e'(field[3:2]), l_in, t_in, b_in);
    t_out = sel3(sel_e'(field[5:4]), l_in, r_in, b_in);
    b_out = sel3(sel_e'(field[7:6]), l_in, r_in, t_in);
  end

endmodule

// File: rtl/switch_box.sv
// switch_box: disjoint-topology routing switch box with serial configuration.
// Track i on any side reaches only track i on the other three sides.
// Ports:
//   config_clk   - configuration clock (only clock of the block)
//   rst          - asynchronous active-high reset, clears the configuration
//   config_en    - shift enable
//   config_in    - serial configuration data in
//   config_out   - serial configuration data out (cfg bit 0), for daisy-chaining
//   l_in/r_in/t_in/b_in     [WIDTH] - track inputs per side
//   l_out/r_out/t_out/b_out [WIDTH] - track outputs per side, combinational from inputs and cfg
// CONFIG_WIDTH must equal 8*WIDTH.
module switch_box
  import switch_box_pkg::*;
#(
  parameter int WIDTH        = 5,
  parameter int CONFIG_WIDTH = 8 * WIDTH
) (
  input  logic             config_clk,
  input  logic             rst,
  input  logic             config_en,
  input  logic             config_in,
  output logic             config_out,
  input  logic [WIDTH-1:0] l_in,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] t_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] l_out,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] t_out,
  output logic [WIDTH-1:0] b_out
);

  logic [CONFIG_WIDTH-1:0] cfg_r;

  // Configuration shift register: new bits enter at the MSB, so the first bit
  // shifted in ends up at cfg_r[0] once the full word has been loaded.
  always_ff @(posedge config_clk or posedge rst) begin
    if (rst) begin
      cfg_r <= '0;
    end else if (config_en) begin
      cfg_r <= {config_in, cfg_r[CONFIG_WIDTH-1:1]};
    end else begin
      cfg_r <= cfg_r;
    end
  end

  // Chain output comes straight from the register, so it only moves after clock edges.
  assign config_out = cfg_r[0];

  // One mux per track index, each owning its own 8-bit configuration field.
  for (genvar i = 0; i < WIDTH; i++) begin : g_track
    sb_track_mux u_mux (
      .field (cfg_r[CFG_BITS_PER_TRACK*i +: CFG_BITS_PER_TRACK]),
      .l_in  (l_in[i]),
      .r_in  (r_in[i]),
      .t_in  (t_in[i]),
      .b_in  (b_in[i]),
      .l_out (l_out[i]),
      .r_out (r_out[i]),
      .t_out (t_out[i]),
      .b_out (b_out[i])
    );
  end

endmodule

// File: tb/tb_switch_box.sv
module tb_switch_box;

  localparam int W  = 5;
  localparam int CW = 40;

  logic          config_clk;
  logic          rst;
  logic          config_en;
  logic          config_in;
  logic          config_out;
  logic [W-1:0]  l_in, r_in, t_in, b_in;
  logic [W-1:0]  l_out, r_out, t_out, b_out;

  switch_box #(.WIDTH(W), .CONFIG_WIDTH(CW)) dut (
    .config_clk (config_clk),
    .rst        (rst),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .l_in       (l_in),
    .r_in       (r_in),
    .t_in       (t_in),
    .b_in       (b_in),
    .l_out      (l_out),
    .r_out      (r_out),
    .t_out      (t_out),
    .b_out      (b_out)
  );

  initial config_clk = 1'b0;
  always #5 config_clk = ~config_clk;

  typedef struct {
    string        name;
    logic [W-1:0] l, r, t, b;
    logic         co;
    bit           co_only;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: samples on the falling edge and compares against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge config_clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_total++;
        if (e.co_only) begin
          if (config_out === e.co) n_pass++;
          else $display("FAIL %s: config_out got %b expected %b", e.name, config_out, e.co);
        end else begin
          if (l_out === e.l && r_out === e.r && t_out === e.t && b_out === e.b && config_out === e.co)
            n_pass++;
          else
            $display("FAIL %s: got l=%b r=%b t=%b b=%b co=%b expected l=%b r=%b t=%b b=%b co=%b",
                     e.name, l_out, r_out, t_out, b_out, config_out, e.l, e.r, e.t, e.b, e.co);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < 4) begin
      @(posedge config_clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL %s: monitor timeout, %0d expectations pending, required 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] l, input logic [W-1:0] r,
                            input logic [W-1:0] t, input logic [W-1:0] b, input logic co);
    exp_t e;
    e.name = nm; e.l = l; e.r = r; e.t = t; e.b = b; e.co = co; e.co_only = 1'b0;
    sb_q.push_back(e);
    drain(nm);
  endtask

  task automatic set_in(input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic [W-1:0] t, input logic [W-1:0] b);
    l_in = l; r_in = r; t_in = t; b_in = b;
  endtask

  // Shifts a word LSB first; optionally expects config_out to present prev[k] before shift k.
  task automatic shift_word(input logic [CW-1:0] w, input bit chk, input logic [CW-1:0] prev);
    exp_t e;
    for (int k = 0; k < CW; k++) begin
      config_en = 1'b1;
      config_in = w[k];
      if (chk) begin
        e.name = $sformatf("chain_bit%0d", k);
        e.l = 5'd0; e.r = 5'd0; e.t = 5'd0; e.b = 5'd0;
        e.co = prev[k]; e.co_only = 1'b1;
        sb_q.push_back(e);
      end
      @(posedge config_clk); #1;
    end
    config_en = 1'b0;
    config_in = 1'b0;
    drain("shift_word");
  endtask

  localparam logic [CW-1:0] CFG_STRAIGHT = 40'hF5F5F5F5F5;
  localparam logic [CW-1:0] CFG_TURN     = 40'h0000000002;
  localparam logic [CW-1:0] CFG_FANOUT   = 40'h0047000000;
  localparam logic [CW-1:0] CFG_MIX_AB   = 40'hABABABABAB;
  localparam logic [CW-1:0] CFG_MIX_1C   = 40'h1C1C1C1C1C;
  localparam logic [CW-1:0] PAT_A        = 40'hC35A960FE1;
  localparam logic [CW-1:0] PAT_B        = 40'h123456789A;
  localparam logic [CW-1:0] ZERO         = 40'h0;

  initial begin
    rst = 1'b1; config_en = 1'b0; config_in = 1'b0;
    set_in(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    @(posedge config_clk); #1;

    // Reset state with arbitrary inputs
    expect_out("reset_state", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Shifting ones while reset is held must leave cfg cleared
    config_en = 1'b1; config_in = 1'b1;
    set_in(5'b11111, 5'b11111, 5'b11111, 5'b11111);
    repeat (45) begin @(posedge config_clk); #1; end
    config_en = 1'b0; config_in = 1'b0;
    expect_out("reset_overrides_shift", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    rst = 1'b0;
    @(posedge config_clk); #1;

    // Straight-through
    set_in(5'd0, 5'd0, 5'd0, 5'd0);
    shift_word(CFG_STRAIGHT, 1'b0, ZERO);
    set_in(5'b10101, 5'd0, 5'd0, 5'd0);
    expect_out("straight_l_to_r", 5'd0, 5'b10101, 5'd0, 5'd0, 1'b1);
    set_in(5'd0, 5'd0, 5'd0, 5'b01010);
    expect_out("straight_b_to_t", 5'd0, 5'd0, 5'b01010, 5'd0, 1'b1);
    set_in(5'd0, 5'b11111, 5'd0, 5'd0);
    expect_out("straight_r_to_l", 5'b11111, 5'd0, 5'd0, 5'd0, 1'b1);
    set_in(5'd0, 5'd0, 5'b00110, 5'd0);
    expect_out("straight_t_to_b", 5'd0, 5'd0, 5'd0, 5'b00110, 1'b1);

    // Hold: config_en low, config_in toggling, outputs must not move
    set_in(5'b10101, 5'b01100, 5'b00111, 5'b11000);
    expect_out("hold_before", 5'b01100, 5'b10101, 5'b11000, 5'b00111, 1'b1);
    for (int k = 0; k < 10; k++) begin
      config_in = k[0];
      @(posedge config_clk); #1;
    end
    config_in = 1'b0;
    expect_out("hold_after", 5'b01100, 5'b10101, 5'b11000, 5'b00111, 1'b1);

    // Turn: track 0 only, l_out = t_in
    shift_word(CFG_TURN, 1'b0, ZERO);
    set_in(5'd0, 5'd0, 5'b00001, 5'd0);
    expect_out("turn_t_to_l", 5'b00001, 5'd0, 5'd0, 5'd0, 1'b0);
    set_in(5'b11111, 5'b11111, 5'b11111, 5'b11111);
    expect_out("turn_other_tracks_off", 5'b00001, 5'd0, 5'd0, 5'd0, 1'b0);

    // Fan-out on track 3
    shift_word(CFG_FANOUT, 1'b0, ZERO);
    set_in(5'b01000, 5'd0, 5'd0, 5'd0);
    expect_out("fanout_l3", 5'd0, 5'b01000, 5'd0, 5'b01000, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 5'b01000);
    expect_out("fanout_b3_to_l", 5'b01000, 5'd0, 5'd0, 5'd0, 1'b0);

    // Remaining select codes
    shift_word(CFG_MIX_AB, 1'b0, ZERO);
    set_in(5'b00011, 5'b00101, 5'b01001, 5'b10001);
    expect_out("mix_ab", 5'b10001, 5'b01001, 5'b00101, 5'b00101, 1'b1);
    shift_word(CFG_MIX_1C, 1'b0, ZERO);
    expect_out("mix_1c", 5'd0, 5'b10001, 5'b00011, 5'd0, 1'b0);

    // Chain: shifting B out pushes A out of config_out, bit 0 first
    set_in(5'd0, 5'd0, 5'd0, 5'd0);
    shift_word(PAT_A, 1'b0, ZERO);
    shift_word(PAT_B, 1'b1, PAT_A);

    // Async reset between edges
    shift_word(CFG_STRAIGHT, 1'b0, ZERO);
    set_in(5'b11111, 5'd0, 5'd0, 5'd0);
    expect_out("async_pre", 5'd0, 5'b11111, 5'd0, 5'd0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (r_out === 5'd0 && config_out === 1'b0) n_pass++;
    else $display("FAIL async_immediate: r_out=%b co=%b expected r_out=00000 co=0", r_out, config_out);
    expect_out("async_reset", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    rst = 1'b0;
    @(posedge config_clk); #1;
    expect_out("after_async_reset", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
